// File: rtl/in_mem_reader.sv
// Streams NUM_PIXELS pixels from a synchronous-read input memory onto a valid/ready
// interface, zero-extending each pixel to DATA_W bits and pulsing done after the last one.
module in_mem_reader #(
    parameter int NUM_PIXELS = 10,
    parameter int ADDR_W     = 4,
    parameter int PIX_W      = 8,
    parameter int DATA_W     = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd,
    input  logic [PIX_W-1:0]  mem_data,
    output logic [DATA_W-1:0] pix_data,
    output logic              pix_valid,
    input  logic              pix_ready,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W:0]   pix_count
);

    // state   | meaning
    // IDLE    | waiting for start
    // WAIT    | memory latency cycle, read data captured at the closing edge
    // PRESENT | pixel on the stream, waiting for the handshake
    // DONE    | one-cycle done pulse, then back to IDLE
    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_PRESENT,
        S_DONE
    } state_t;

    typedef logic [ADDR_W:0] cnt_t;
    localparam cnt_t LAST_CNT = cnt_t'(NUM_PIXELS - 1);

    state_t            state;
    state_t            state_nxt;
    logic [ADDR_W-1:0] addr_q;
    logic              handshake;
    logic              last_pix;

    assign handshake = pix_valid & pix_ready;
    assign last_pix  = (pix_count == LAST_CNT);

    // The read is issued combinationally in the cycle before WAIT so the memory's
    // one-cycle latency lands inside WAIT, giving one pixel every two cycles.
    always_comb begin
        state_nxt = state;
        mem_rd    = 1'b0;
        mem_addr  = addr_q;
        done      = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    mem_rd    = 1'b1;
                    mem_addr  = '0;
                    state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                state_nxt = S_PRESENT;
            end
            S_PRESENT: begin
                if (handshake) begin
                    if (last_pix) begin
                        state_nxt = S_DONE;
                    end else begin
                        mem_rd    = 1'b1;
                        mem_addr  = addr_q + ADDR_W'(1);
                        state_nxt = S_WAIT;
                    end
                end
            end
            S_DONE: begin
                done      = 1'b1;
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q    <= '0;
            pix_data  <= '0;
            pix_valid <= 1'b0;
            busy      <= 1'b0;
            pix_count <= '0;
        end else begin
            if (mem_rd) begin
                addr_q <= mem_addr;
            end
            case (state)
                S_IDLE: begin
                    if (start) begin
                        busy      <= 1'b1;
                        pix_count <= '0;
                    end
                end
                S_WAIT: begin
                    pix_data  <= DATA_W'(mem_data);
                    pix_valid <= 1'b1;
                end
                S_PRESENT: begin
                    if (handshake) begin
                        pix_valid <= 1'b0;
                        pix_count <= pix_count + cnt_t'(1);
                    end
                end
                S_DONE: begin
                    busy <= 1'b0;
                end
                default: begin
                    busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_in_mem_reader.sv
// Self-checking bench for in_mem_reader: table-driven frames, hand-written corner
// sequences and a per-cycle reference model of the pixel stream.
module tb_in_mem_reader;

    localparam int N = 10;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [3:0]  mem_addr;
    logic        mem_rd;
    logic [7:0]  mem_data;
    logic [31:0] pix_data;
    logic        pix_valid;
    logic        pix_ready;
    logic        busy;
    logic        done;
    logic [4:0]  pix_count;

    in_mem_reader #(
        .NUM_PIXELS(N),
        .ADDR_W    (4),
        .PIX_W     (8),
        .DATA_W    (32)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .mem_addr (mem_addr),
        .mem_rd   (mem_rd),
        .mem_data (mem_data),
        .pix_data (pix_data),
        .pix_valid(pix_valid),
        .pix_ready(pix_ready),
        .busy     (busy),
        .done     (done),
        .pix_count(pix_count)
    );

    always #5 clk = ~clk;

    // Synchronous-read memory; outside a read the data bus carries garbage.
    logic [7:0] mem [16];
    always @(posedge clk) mem_data <= mem_rd ? mem[mem_addr] : 8'($urandom);

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state: what the stream must look like, frame by frame.
    bit          m_busy;
    bit          m_done_next;
    bit          hold_prev;
    logic [31:0] hold_data;
    int          m_count;
    int          m_reads;
    int          m_idx;
    int          frame_hs;
    int          hs_total   = 0;
    int          done_total = 0;
    int          max_addr   = 0;
    logic [31:0] first_hs;
    logic [31:0] last_hs;

    typedef struct {
        logic [7:0]  base;
        logic [7:0]  step;
        int          ready_pct;
        int          exp_done_cyc;
        logic [31:0] exp_first;
        logic [31:0] exp_last;
    } vec_t;

    vec_t vecs[5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        m_busy      = 1'b0;
        m_done_next = 1'b0;
        hold_prev   = 1'b0;
        m_count     = 0;
        m_reads     = 0;
        m_idx       = 0;
        frame_hs    = 0;
    endtask

    function automatic logic rnd_ready(input int pct);
        if (pct >= 100) return 1'b1;
        return ($urandom_range(99) < pct) ? 1'b1 : 1'b0;
    endfunction

    // One clock cycle: drive inputs after the falling edge, then check the
    // settled outputs against the model before the next rising edge.
    task automatic tick(input logic s, input logic r);
        bit start_acc;
        bit hs;
        bit exp_done;
        @(negedge clk);
        start     = s;
        pix_ready = r;
        #3;
        if (!rst_n) begin
            model_clear();
            return;
        end
        start_acc = s && !m_busy;
        exp_done  = m_done_next;
        if (start_acc) begin
            m_reads  = 0;
            m_idx    = 0;
            frame_hs = 0;
        end
        chk("busy", 32'(busy), 32'(m_busy));
        chk("done", 32'(done), 32'(exp_done));
        chk("pix_count", 32'(pix_count), m_count);
        if (!m_busy) chk("valid_idle", 32'(pix_valid), 0);
        if (hold_prev) begin
            chk("hold_valid", 32'(pix_valid), 1);
            chk("hold_data", pix_data, hold_data);
        end
        if (mem_rd) begin
            chk("rd_addr", 32'(mem_addr), m_reads);
            if (int'(mem_addr) > max_addr) max_addr = int'(mem_addr);
            m_reads++;
        end
        hs = pix_valid && pix_ready;
        if (hs) begin
            if (m_idx < N) begin
                chk("pix_data", pix_data, {24'h0, mem[m_idx]});
            end else begin
                chk("extra_transfer", m_idx, N - 1);
            end
            if (m_idx == 0) first_hs = pix_data;
            last_hs = pix_data;
            m_idx++;
            m_count++;
            frame_hs++;
            hs_total++;
        end
        if (done) done_total++;
        hold_prev   = pix_valid && !pix_ready;
        hold_data   = pix_data;
        m_done_next = hs && (m_idx == N);
        if (exp_done) m_busy = 1'b0;
        if (start_acc) begin
            m_busy  = 1'b1;
            m_count = 0;
        end
    endtask

    task automatic finish_frame(input int pct, output int done_cyc);
        done_cyc = -1;
        for (int c = 1; c <= 400; c++) begin
            tick(1'b0, rnd_ready(pct));
            if (done) begin
                done_cyc = c;
                break;
            end
        end
        chk("done_seen", 32'(done_cyc > 0), 1);
    endtask

    task automatic run_frame(input int pct, output int done_cyc);
        int dc;
        tick(1'b1, rnd_ready(pct));
        finish_frame(pct, dc);
        done_cyc = dc;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_addr"}, 32'(mem_addr), 0);
        chk({tag, "_rd"}, 32'(mem_rd), 0);
        chk({tag, "_data"}, pix_data, 0);
        chk({tag, "_valid"}, 32'(pix_valid), 0);
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_done"}, 32'(done), 0);
        chk({tag, "_count"}, 32'(pix_count), 0);
    endtask

    initial begin
        int dc;
        int hs0;
        int d0;
        vecs[0] = '{8'h10, 8'h01, 100, 21, 32'h0000_0010, 32'h0000_0019};
        vecs[1] = '{8'hF6, 8'h01, 100, 21, 32'h0000_00F6, 32'h0000_00FF};
        vecs[2] = '{8'h00, 8'h1C, 50, 0, 32'h0000_0000, 32'h0000_00FC};
        vecs[3] = '{8'h55, 8'hFF, 30, 0, 32'h0000_0055, 32'h0000_004C};
        vecs[4] = '{8'hA0, 8'h20, 100, 21, 32'h0000_00A0, 32'h0000_00C0};

        for (int i = 0; i < 16; i++) mem[i] = 8'($urandom);
        model_clear();
        rst_n     = 1'b0;
        start     = 1'b0;
        pix_ready = 1'b0;
        #12;
        check_reset_outputs("reset");
        tick(1'b0, 1'b0);
        rst_n = 1'b1;
        tick(1'b0, 1'b0);

        // Table-driven frames
        foreach (vecs[v]) begin
            for (int i = 0; i < N; i++) mem[i] = vecs[v].base + 8'(i) * vecs[v].step;
            run_frame(vecs[v].ready_pct, dc);
            if (vecs[v].exp_done_cyc > 0) chk("done_latency", dc, vecs[v].exp_done_cyc);
            chk("first_pix", first_hs, vecs[v].exp_first);
            chk("last_pix", last_hs, vecs[v].exp_last);
            chk("frame_transfers", frame_hs, N);
            tick(1'b0, 1'b0);
            chk("busy_after_done", 32'(busy), 0);
            chk("count_final", 32'(pix_count), N);
        end

        // Backpressure on pixel 4
        for (int i = 0; i < N; i++) mem[i] = 8'h10 + 8'(i);
        tick(1'b1, 1'b1);
        repeat (9) tick(1'b0, 1'b1);
        for (int k = 0; k < 5; k++) begin
            tick(1'b0, 1'b0);
            chk("bp_valid", 32'(pix_valid), 1);
            chk("bp_data", pix_data, 32'h0000_0014);
            chk("bp_rd", 32'(mem_rd), 0);
            chk("bp_addr", 32'(mem_addr), 4);
        end
        tick(1'b0, 1'b1);
        tick(1'b0, 1'b1);
        tick(1'b0, 1'b1);
        chk("resume_valid", 32'(pix_valid), 1);
        chk("resume_data", pix_data, 32'h0000_0015);
        finish_frame(100, dc);

        // Start pulses while busy and during DONE
        for (int i = 0; i < N; i++) mem[i] = 8'($urandom);
        hs0 = hs_total;
        d0  = done_total;
        tick(1'b1, 1'b1);
        for (int c = 1; c <= 40; c++) tick((c == 5 || c == 6 || c == 21) ? 1'b1 : 1'b0, 1'b1);
        chk("busy_start_transfers", hs_total - hs0, N);
        chk("busy_start_dones", done_total - d0, 1);

        // Reset in the middle of a frame
        for (int i = 0; i < N; i++) mem[i] = 8'($urandom);
        tick(1'b1, 1'b1);
        for (int c = 0; c < 40; c++) begin
            tick(1'b0, 1'b1);
            if (frame_hs == 3) break;
        end
        chk("abort_progress", frame_hs, 3);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("async_reset");
        model_clear();
        d0 = done_total;
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b0);
        rst_n = 1'b1;
        repeat (4) tick(1'b0, 1'b0);
        chk("no_done_after_abort", done_total - d0, 0);
        for (int i = 0; i < N; i++) mem[i] = 8'($urandom);
        run_frame(100, dc);
        chk("restart_first", first_hs, {24'h0, mem[0]});
        chk("restart_latency", dc, 21);

        // Zero-extension and address boundary
        for (int i = 0; i < N; i++) mem[i] = 8'($urandom);
        mem[0] = 8'h80;
        mem[9] = 8'hFF;
        run_frame(70, dc);
        chk("zext_first", first_hs, 32'h0000_0080);
        chk("zext_last", last_hs, 32'h0000_00FF);
        chk("max_addr", max_addr, N - 1);

        // Randomized frames with random gaps and stray start/ready activity
        for (int f = 0; f < 6; f++) begin
            for (int i = 0; i < 16; i++) mem[i] = 8'($urandom);
            repeat ($urandom_range(3)) tick(1'b0, 1'($urandom));
            tick(1'b1, 1'($urandom));
            dc = -1;
            for (int c = 1; c <= 400; c++) begin
                tick(1'($urandom_range(9) == 0), rnd_ready(20 + 15 * f));
                if (done) begin
                    dc = c;
                    break;
                end
            end
            chk("rand_done_seen", 32'(dc > 0), 1);
            chk("rand_transfers", frame_hs, N);
        end
        tick(1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/in_mem_reader.md
Name: in_mem_reader

Overview:
- Input-side counterpart of the output pixel memory.
- Fetches NUM_PIXELS 8-bit pixels in address order from a synchronous-read input memory.
- Presents each pixel zero-extended to 32 bits on a valid/ready stream into the processing datapath, one transfer per pixel.
- Signals done once the last pixel has been accepted.

Parameters:
- NUM_PIXELS, 10, number of pixels streamed per frame (≥1).
- ADDR_W, 4, memory address width; must satisfy 2^ADDR_W ≥ NUM_PIXELS.
- PIX_W, 8, pixel width stored in memory.
- DATA_W, 32, width of the output word (≥ PIX_W).

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle request to stream a frame; sampled only in IDLE.
- mem_addr  out  ADDR_W  read address to input memory.
- mem_rd  out  1  read strobe; memory returns data on mem_data the cycle after mem_rd=1.
- mem_data  in  PIX_W  read data, valid exactly 1 cycle after mem_rd.
- pix_data  out  DATA_W  pixel, zero-extended: upper DATA_W-PIX_W bits 0.
- pix_valid  out  1  pix_data holds a pixel not yet accepted.
- pix_ready  in  1  consumer accepts when pix_valid & pix_ready at a rising edge.
- busy  out  1  high from the cycle after start until done pulses.
- done  out  1  one-cycle pulse after the last pixel is accepted.
- pix_count  out  ADDR_W+1  number of pixels accepted in current/last frame.

Behaviour:
- Reset (async, rst_n=0): state=IDLE; mem_addr=0, mem_rd=0, pix_data=0, pix_valid=0, busy=0, done=0, pix_count=0. Deassertion is taken synchronously by the next edge; a reset mid-frame abandons the frame with no done pulse.
- States: IDLE, WAIT, PRESENT, DONE.
- IDLE:
  - start=1 → mem_addr=0, mem_rd=1, busy=1, pix_count=0 → WAIT.
  - start=0 → stay; mem_rd=0.
- WAIT (memory latency cycle):
  - mem_rd=0.
  - At the edge, pix_data ← {0, mem_data}, pix_valid ← 1 → PRESENT.
- PRESENT:
  - pix_data and pix_valid are held stable while pix_ready=0; no timeout.
  - On handshake (pix_valid & pix_ready), pix_count increments and pix_valid ← 0.
  - If pix_count (before increment) = NUM_PIXELS-1 → DONE.
  - Otherwise mem_addr ← mem_addr+1, mem_rd ← 1 → WAIT.
- DONE: done=1 for exactly this one cycle; busy ← 0 → IDLE. pix_count keeps the final value (NUM_PIXELS) until the next start.
- Latency:
  - start edge to first pix_valid: 2 cycles.
  - Handshake edge to next pix_valid: 2 cycles.
  - Peak throughput: 1 pixel / 2 cycles.
  - Last handshake to done: 1 cycle.
- Address: strictly 0..NUM_PIXELS-1, never wraps within a frame; each address read exactly once per frame. Returns to 0 only on the next start.
- start while busy or in DONE: ignored, with no effect on the current frame.
- pix_ready while pix_valid=0: ignored.
- mem_data is sampled only in the WAIT cycle; values at other times are don't-care.
- NUM_PIXELS=1: a single WAIT/PRESENT pass, then DONE.

Test Plan:
- Reset mid-frame: start, accept 3 pixels, then pulse rst_n low → all outputs 0 immediately (async); next start re-reads from address 0; no done pulse for the aborted frame.
- Basic frame:
  - Stimulus: memory = 0x10,0x11,…,0x19; pix_ready tied 1; start pulse.
  - Required: pix_data = 0x00000010…0x00000019 in order; first pix_valid 2 cycles after start; pixel every 2 cycles; done one cycle after the 10th handshake; pix_count=10; busy low after done.
- Backpressure:
  - Stimulus: pix_ready=0 for 5 cycles while pixel 4 (0x14) is valid.
  - Required: pix_data holds 0x00000014, pix_valid stays 1, mem_rd stays 0, mem_addr holds 4; resume yields 0x15 next.
- Start while busy: second start pulse during pixel 2 → stream unaffected, exactly 10 transfers, single done pulse.
- Zero-extension / boundary: memory[9]=0xFF, memory[0]=0x80 → pix_data 0x000000FF and 0x00000080; mem_addr never exceeds 9.
